// File: rtl/wb_occf_sink_arbiter.sv
// Packet-level round-robin arbiter sharing one OCC fabric sink between g_NUM_SRC sources.
// A source owns the link from cyc rise to cyc fall; responses still in flight afterwards are drained.
module wb_occf_sink_arbiter #(
  parameter int unsigned g_NUM_SRC         = 2,
  parameter int unsigned g_ADDR_WIDTH      = 4,
  parameter int unsigned g_DATA_WIDTH      = 128,
  parameter int unsigned g_MAX_OUTSTANDING = 15
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [g_NUM_SRC*g_DATA_WIDTH-1:0]     snk_dat_i,
  input  logic [g_NUM_SRC*g_ADDR_WIDTH-1:0]     snk_adr_i,
  input  logic [g_NUM_SRC*(g_DATA_WIDTH/8)-1:0] snk_sel_i,
  input  logic [g_NUM_SRC-1:0]                  snk_cyc_i,
  input  logic [g_NUM_SRC-1:0]                  snk_stb_i,
  input  logic [g_NUM_SRC-1:0]                  snk_we_i,
  output logic [g_NUM_SRC-1:0]                  snk_stall_o,
  output logic [g_NUM_SRC-1:0]                  snk_ack_o,
  output logic [g_NUM_SRC-1:0]                  snk_err_o,
  output logic [g_NUM_SRC-1:0]                  snk_rty_o,
  output logic [g_DATA_WIDTH-1:0]               src_dat_o,
  output logic [g_ADDR_WIDTH-1:0]               src_adr_o,
  output logic [g_DATA_WIDTH/8-1:0]             src_sel_o,
  output logic                                  src_cyc_o,
  output logic                                  src_stb_o,
  output logic                                  src_we_o,
  input  logic                                  src_stall_i,
  input  logic                                  src_ack_i,
  input  logic                                  src_err_i,
  input  logic                                  src_rty_i,
  output logic [g_NUM_SRC-1:0]                  grant_o,
  output logic                                  busy_o,
  output logic                                  proto_err_o
);
  localparam int unsigned SW = g_DATA_WIDTH / 8;
  localparam int unsigned IW = $clog2(g_NUM_SRC);
  localparam int unsigned CW = $clog2(g_MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_OUT  = CW'(g_MAX_OUTSTANDING);
  localparam logic [IW-1:0] LAST_RST = IW'(g_NUM_SRC - 1);
  localparam logic [g_NUM_SRC-1:0] ONE_HOT0 = {{(g_NUM_SRC-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN} state_t;

  state_t        state;
  logic [IW-1:0] cur;
  logic [IW-1:0] last;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  logic          found;
  logic [CW-1:0] outst;
  logic [CW-1:0] outst_nxt;
  logic          accept;
  logic          resp;
  logic          ovf;

  // Round-robin search starting just above the previous winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= g_NUM_SRC; i++) begin
      cand = IW'((32'(last) + i) % g_NUM_SRC);
      if (!found && snk_cyc_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    accept    = src_stb_o & ~src_stall_i;
    resp      = (state != S_IDLE) & (src_ack_i | src_err_i | src_rty_i);
    outst_nxt = outst;
    ovf       = 1'b0;
    if (accept && !resp) begin
      if (outst == MAX_OUT) ovf = 1'b1;
      else                  outst_nxt = outst + 1'b1;
    end else if (resp && !accept && outst != '0) begin
      outst_nxt = outst - 1'b1;
    end
  end

  always_comb begin
    src_dat_o   = '0;
    src_adr_o   = '0;
    src_sel_o   = '0;
    src_cyc_o   = 1'b0;
    src_stb_o   = 1'b0;
    src_we_o    = 1'b0;
    snk_stall_o = '1;
    snk_ack_o   = '0;
    snk_err_o   = '0;
    snk_rty_o   = '0;
    case (state)
      S_GRANT: begin
        src_dat_o = snk_dat_i[cur*g_DATA_WIDTH +: g_DATA_WIDTH];
        src_adr_o = snk_adr_i[cur*g_ADDR_WIDTH +: g_ADDR_WIDTH];
        src_sel_o = snk_sel_i[cur*SW +: SW];
        // cyc stays up while strobes are outstanding so an early cyc drop hands over to DRAIN without a gap
        src_cyc_o = snk_cyc_i[cur] | (outst != '0);
        src_stb_o = snk_stb_i[cur];
        src_we_o  = snk_we_i[cur];
        snk_stall_o[cur] = src_stall_i;
        snk_ack_o[cur]   = src_ack_i;
        snk_err_o[cur]   = src_err_i;
        snk_rty_o[cur]   = src_rty_i;
      end
      S_DRAIN: src_cyc_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      cur         <= '0;
      last        <= LAST_RST;
      outst       <= '0;
      grant_o     <= '0;
      busy_o      <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      outst       <= outst_nxt;
      proto_err_o <= ovf;
      case (state)
        S_IDLE: begin
          if (|snk_cyc_i) begin
            state   <= S_GRANT;
            cur     <= win;
            grant_o <= ONE_HOT0 << win;
            busy_o  <= 1'b1;
          end
        end
        S_GRANT: begin
          if (!snk_cyc_i[cur]) begin
            last    <= cur;
            grant_o <= '0;
            if (outst_nxt == '0) begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end else begin
              state       <= S_DRAIN;
              proto_err_o <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (outst_nxt == '0) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_occf_sink_arbiter.sv
// Directed bench for wb_occf_sink_arbiter: two sources, one shared sink modelled in the stimulus tasks.
module tb_wb_occf_sink_arbiter;
  localparam int N  = 2;
  localparam int AW = 4;
  localparam int DW = 128;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*DW-1:0] snk_dat = '0;
  logic [N*AW-1:0] snk_adr = '0;
  logic [N*SW-1:0] snk_sel = '0;
  logic [N-1:0]    snk_cyc = '0, snk_stb = '0, snk_we = '0;
  logic [N-1:0]    snk_stall, snk_ack, snk_err, snk_rty;
  logic [DW-1:0]   src_dat;
  logic [AW-1:0]   src_adr;
  logic [SW-1:0]   src_sel;
  logic            src_cyc, src_stb, src_we;
  logic            src_stall = 1'b0, src_ack = 1'b0, src_err = 1'b0, src_rty = 1'b0;
  logic [N-1:0]    grant;
  logic            busy, proto_err;

  int n_cmp = 0;
  int n_bad = 0;

  wb_occf_sink_arbiter #(
    .g_NUM_SRC(N), .g_ADDR_WIDTH(AW), .g_DATA_WIDTH(DW), .g_MAX_OUTSTANDING(15)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .snk_dat_i(snk_dat), .snk_adr_i(snk_adr), .snk_sel_i(snk_sel),
    .snk_cyc_i(snk_cyc), .snk_stb_i(snk_stb), .snk_we_i(snk_we),
    .snk_stall_o(snk_stall), .snk_ack_o(snk_ack), .snk_err_o(snk_err), .snk_rty_o(snk_rty),
    .src_dat_o(src_dat), .src_adr_o(src_adr), .src_sel_o(src_sel),
    .src_cyc_o(src_cyc), .src_stb_o(src_stb), .src_we_o(src_we),
    .src_stall_i(src_stall), .src_ack_i(src_ack), .src_err_i(src_err), .src_rty_i(src_rty),
    .grant_o(grant), .busy_o(busy), .proto_err_o(proto_err)
  );

  function automatic logic [DW-1:0] beat(input int s, input int i);
    return {32'hC0DE_0000 + 32'(s), 32'(i), ~32'(i), 32'(s * 256 + i)};
  endfunction

  task automatic set_src(input int s, input logic c, input logic st, input logic [DW-1:0] d);
    snk_cyc[s] = c;
    snk_stb[s] = st;
    snk_we[s]  = st;
    snk_dat[s*DW +: DW] = d;
    snk_adr[s*AW +: AW] = d[AW-1:0];
    snk_sel[s*SW +: SW] = '1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL rst_grant: got %b, want 00", grant); end
    n_cmp++; if ({busy, proto_err} !== 2'b00) begin n_bad++; $display("FAIL rst_busy_perr: got %b, want 00", {busy, proto_err}); end
    n_cmp++; if ({src_cyc, src_stb, src_we} !== 3'b000) begin n_bad++; $display("FAIL rst_src_ctl: got %b, want 000", {src_cyc, src_stb, src_we}); end
    n_cmp++; if (snk_stall !== 2'b11) begin n_bad++; $display("FAIL rst_stall: got %b, want 11", snk_stall); end
    n_cmp++; if ({snk_ack, snk_err, snk_rty} !== 6'b0) begin n_bad++; $display("FAIL rst_resp: got %b, want 000000", {snk_ack, snk_err, snk_rty}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int acks = 0;
    logic perr = 1'b0;
    src_stall = 1'b0;
    set_src(1, 1'b1, 1'b1, beat(1, 0));
    #1;
    n_cmp++; if ({snk_stall, src_cyc} !== 3'b110) begin n_bad++; $display("FAIL single_idle: got %b, want 110", {snk_stall, src_cyc}); end
    tick();
    n_cmp++; if ({grant, busy} !== 3'b101) begin n_bad++; $display("FAIL single_grant: got %b, want 101", {grant, busy}); end
    for (int i = 0; i < 4; i++) begin
      set_src(1, 1'b1, 1'b1, beat(1, i));
      src_ack = (i > 0);
      #1;
      n_cmp++; if (src_dat !== beat(1, i)) begin n_bad++; $display("FAIL single_dat[%0d]: got %h, want %h", i, src_dat, beat(1, i)); end
      n_cmp++; if ({snk_stall, src_cyc} !== 3'b011) begin n_bad++; $display("FAIL single_stall[%0d]: got %b, want 011", i, {snk_stall, src_cyc}); end
      if (snk_ack[1]) acks++;
      perr |= proto_err;
      tick();
    end
    set_src(1, 1'b1, 1'b0, '0);
    src_ack = 1'b1;
    #1;
    if (snk_ack[1]) acks++;
    n_cmp++; if (snk_ack[0] !== 1'b0 || snk_stall[0] !== 1'b1) begin n_bad++; $display("FAIL single_src0: got ack=%b stall=%b, want 0 1", snk_ack[0], snk_stall[0]); end
    tick();
    set_src(1, 1'b0, 1'b0, '0);
    src_ack = 1'b0;
    #1;
    n_cmp++; if (src_cyc !== 1'b0) begin n_bad++; $display("FAIL single_release_cyc: got %b, want 0", src_cyc); end
    perr |= proto_err;
    tick();
    perr |= proto_err;
    n_cmp++; if ({grant, busy, perr} !== 4'b0000) begin n_bad++; $display("FAIL single_idle_after: got %b, want 0000", {grant, busy, perr}); end
    n_cmp++; if (acks !== 4) begin n_bad++; $display("FAIL single_acks: got %0d, want 4", acks); end
  endtask

  task automatic test_alternate();
    int pk[2] = '{3, 3};
    int sent[2] = '{0, 0};
    int acked[2] = '{0, 0};
    int seq[$];
    int rises = 0;
    int n_sink = 0;
    int cnt;
    logic acc_q = 1'b0;
    logic [N-1:0] prev_grant = grant;
    logic prev_cyc = src_cyc;
    src_stall = 1'b0;
    for (cnt = 0; cnt < 300 && (pk[0] > 0 || pk[1] > 0); cnt++) begin
      src_ack = acc_q;
      for (int s = 0; s < 2; s++) begin
        if (pk[s] > 0 && !(sent[s] == 2 && acked[s] == 2)) set_src(s, 1'b1, sent[s] < 2, beat(s, sent[s]));
        else set_src(s, 1'b0, 1'b0, '0);
      end
      #1;
      if (grant != '0 && prev_grant == '0) seq.push_back(grant[1] ? 1 : 0);
      if (src_cyc && !prev_cyc) rises++;
      if (src_stb && !src_stall) n_sink++;
      prev_grant = grant;
      prev_cyc = src_cyc;
      acc_q = 1'b0;
      for (int s = 0; s < 2; s++) begin
        if (snk_ack[s]) acked[s]++;
        if (snk_cyc[s] && snk_stb[s] && !snk_stall[s]) begin sent[s]++; acc_q = 1'b1; end
        if (!snk_cyc[s] && sent[s] == 2 && acked[s] == 2) begin pk[s]--; sent[s] = 0; acked[s] = 0; end
      end
      tick();
    end
    src_ack = 1'b0;
    n_cmp++; if (pk[0] != 0 || pk[1] != 0) begin n_bad++; $display("FAIL alt_timeout: got %0d/%0d packets left, want 0/0", pk[0], pk[1]); end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (k >= seq.size() || seq[k] != (k % 2)) begin
        n_bad++; $display("FAIL alt_grant[%0d]: got %0d, want %0d", k, (k < seq.size()) ? seq[k] : -1, k % 2);
      end
    end
    n_cmp++; if (rises != 6) begin n_bad++; $display("FAIL alt_packets: got %0d, want 6", rises); end
    n_cmp++; if (n_sink != 12) begin n_bad++; $display("FAIL alt_beats: got %0d, want 12", n_sink); end
  endtask

  task automatic test_stall();
    int sent = 0, acked = 0, nacc = 0, n_e = 0, n_r = 0, resp_idx = 0;
    logic acc_q = 1'b0, done = 1'b0, perr = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      src_stall = 1'($urandom_range(0, 1));
      src_ack = acc_q && resp_idx != 5 && resp_idx != 9;
      src_err = acc_q && resp_idx == 5;
      src_rty = acc_q && resp_idx == 9;
      if (sent == 16 && acked == 16) set_src(0, 1'b0, 1'b0, '0);
      else set_src(0, 1'b1, sent < 16, beat(0, sent));
      #1;
      acc_q = 1'b0;
      if (src_stb && !src_stall) begin
        n_cmp++; if (src_dat !== beat(0, nacc)) begin n_bad++; $display("FAIL stall_dat[%0d]: got %h, want %h", nacc, src_dat, beat(0, nacc)); end
        resp_idx = nacc;
        nacc++;
        acc_q = 1'b1;
      end
      if (snk_ack[0] || snk_err[0] || snk_rty[0]) acked++;
      if (snk_err[0]) n_e++;
      if (snk_rty[0]) n_r++;
      if (snk_cyc[0] && snk_stb[0] && !snk_stall[0]) sent++;
      perr |= proto_err;
      if (!snk_cyc[0]) done = 1'b1;
      tick();
    end
    {src_stall, src_ack, src_err, src_rty} = 4'b0;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL stall_timeout: got sent=%0d acked=%0d, want 16 16", sent, acked); end
    n_cmp++; if (nacc != 16 || acked != 16) begin n_bad++; $display("FAIL stall_count: got %0d/%0d, want 16/16", nacc, acked); end
    n_cmp++; if (n_e != 1 || n_r != 1) begin n_bad++; $display("FAIL stall_errrty: got %0d/%0d, want 1/1", n_e, n_r); end
    n_cmp++; if ({perr, busy} !== 2'b00) begin n_bad++; $display("FAIL stall_end: got %b, want 00", {perr, busy}); end
  endtask

  task automatic test_reset_mid();
    logic acc_q = 1'b0;
    int sent = 0;
    src_stall = 1'b0;
    set_src(1, 1'b1, 1'b1, beat(1, 0));
    tick();
    n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("FAIL rmid_grant1: got %b, want 10", grant); end
    for (int i = 0; i < 5; i++) begin
      src_ack = acc_q;
      set_src(1, 1'b1, 1'b1, beat(1, sent));
      #1;
      acc_q = snk_stb[1] && !snk_stall[1];
      if (acc_q) sent++;
      tick();
    end
    src_ack = 1'b0;
    set_src(0, 1'b1, 1'b1, beat(0, 0));
    rst = 1'b1;
    #1;
    n_cmp++; if ({grant, busy, proto_err} !== 4'b0000) begin n_bad++; $display("FAIL rmid_regs: got %b, want 0000", {grant, busy, proto_err}); end
    n_cmp++; if ({src_cyc, src_stb, src_we} !== 3'b000) begin n_bad++; $display("FAIL rmid_src_ctl: got %b, want 000", {src_cyc, src_stb, src_we}); end
    n_cmp++; if ({snk_stall, snk_ack} !== 4'b1100) begin n_bad++; $display("FAIL rmid_snk: got %b, want 1100", {snk_stall, snk_ack}); end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if ({grant, busy} !== 3'b011) begin n_bad++; $display("FAIL rmid_first_after: got %b, want 011", {grant, busy}); end
    set_src(0, 1'b0, 1'b0, '0);
    set_src(1, 1'b0, 1'b0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_drain();
    src_stall = 1'b0;
    set_src(0, 1'b1, 1'b1, beat(0, 0));
    tick();
    n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL drain_grant0: got %b, want 01", grant); end
    set_src(1, 1'b1, 1'b1, beat(1, 0));
    #1;
    n_cmp++; if (snk_stall !== 2'b10) begin n_bad++; $display("FAIL drain_stall: got %b, want 10", snk_stall); end
    tick();
    set_src(0, 1'b1, 1'b1, beat(0, 1));
    tick();
    set_src(0, 1'b0, 1'b0, '0);
    #1;
    n_cmp++; if (src_cyc !== 1'b1) begin n_bad++; $display("FAIL drain_cyc_hold: got %b, want 1", src_cyc); end
    tick();
    n_cmp++; if ({proto_err, busy, grant} !== 4'b1100) begin n_bad++; $display("FAIL drain_enter: got %b, want 1100", {proto_err, busy, grant}); end
    src_ack = 1'b1;
    #1;
    n_cmp++; if ({src_cyc, src_stb, snk_ack} !== 4'b1000) begin n_bad++; $display("FAIL drain_ack1: got %b, want 1000", {src_cyc, src_stb, snk_ack}); end
    tick();
    n_cmp++; if ({proto_err, busy} !== 2'b01) begin n_bad++; $display("FAIL drain_pulse_once: got %b, want 01", {proto_err, busy}); end
    src_ack = 1'b0;
    src_rty = 1'b1;
    #1;
    n_cmp++; if ({src_cyc, snk_rty} !== 3'b100) begin n_bad++; $display("FAIL drain_rty: got %b, want 100", {src_cyc, snk_rty}); end
    tick();
    src_rty = 1'b0;
    #1;
    n_cmp++; if ({busy, src_cyc, grant} !== 4'b0000) begin n_bad++; $display("FAIL drain_idle: got %b, want 0000", {busy, src_cyc, grant}); end
    tick();
    n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("FAIL drain_next_grant: got %b, want 10", grant); end
    tick();
    set_src(1, 1'b1, 1'b0, '0);
    src_ack = 1'b1;
    tick();
    set_src(1, 1'b0, 1'b0, '0);
    src_ack = 1'b0;
    tick();
    n_cmp++; if ({busy, proto_err} !== 2'b00) begin n_bad++; $display("FAIL drain_src1_done: got %b, want 00", {busy, proto_err}); end
  endtask

  task automatic test_overflow();
    src_stall = 1'b0;
    set_src(0, 1'b1, 1'b1, beat(0, 0));
    tick();
    for (int i = 0; i < 16; i++) begin
      set_src(0, 1'b1, 1'b1, beat(0, i));
      tick();
      n_cmp++; if (proto_err !== (i == 15)) begin n_bad++; $display("FAIL ovf_perr[%0d]: got %b, want %b", i, proto_err, i == 15); end
    end
    set_src(0, 1'b0, 1'b0, '0);
    #1;
    n_cmp++; if (src_cyc !== 1'b1) begin n_bad++; $display("FAIL ovf_cyc_hold: got %b, want 1", src_cyc); end
    tick();
    n_cmp++; if ({proto_err, busy} !== 2'b11) begin n_bad++; $display("FAIL ovf_drain: got %b, want 11", {proto_err, busy}); end
    for (int j = 1; j <= 15; j++) begin
      src_ack = 1'b1;
      tick();
      n_cmp++; if (busy !== (j < 15)) begin n_bad++; $display("FAIL ovf_drain_busy[%0d]: got %b, want %b", j, busy, j < 15); end
    end
    src_ack = 1'b0;
    #1;
    n_cmp++; if (src_cyc !== 1'b0) begin n_bad++; $display("FAIL ovf_final_cyc: got %b, want 0", src_cyc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_reset_mid();
    test_drain();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_occf_sink_arbiter.md
# wb_occf_sink_arbiter

Packet-level round-robin arbiter that shares one OCC fabric sink (the wishbone-stream input of `wb_occf_sink`) between `g_NUM_SRC` fabric sources. A source owns the shared link for its whole wishbone cycle, from `cyc` rise to `cyc` fall, so packets are never interleaved. The block sits between the per-channel packet sources and the single sink instance. It also drains outstanding transfers when a source misbehaves.

## Interface
- `g_NUM_SRC`, 2: number of requesting sources, 2..8.
- `g_ADDR_WIDTH`, 4: fabric address width.
- `g_DATA_WIDTH`, 128: fabric data width; select width is `g_DATA_WIDTH/8`.
- `g_MAX_OUTSTANDING`, 15: maximum number of unacknowledged strobes; sets the outstanding counter width as `$clog2(g_MAX_OUTSTANDING+1)`.

Ports (vectors are flattened; source k occupies slice k):
- `clk_i`  in  1  system clock; the only clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `snk_dat_i`  in  N*DW  source data.
- `snk_adr_i`  in  N*AW  source address.
- `snk_sel_i`  in  N*DW/8  source byte selects.
- `snk_cyc_i`, `snk_stb_i`, `snk_we_i`  in  N each  source cycle, strobe and write-enable.
- `snk_stall_o`, `snk_ack_o`, `snk_err_o`, `snk_rty_o`  out  N each  per-source responses.
- `src_dat_o`, `src_adr_o`, `src_sel_o`, `src_cyc_o`, `src_stb_o`, `src_we_o`  out  DW/AW/DW/8/1/1/1  to the shared sink.
- `src_stall_i`, `src_ack_i`, `src_err_i`, `src_rty_i`  in  1 each  from the shared sink.
- `grant_o`  out  N  one-hot current owner; zero when idle.
- `busy_o`  out  1  high when the state is GRANT or DRAIN.
- `proto_err_o`  out  1  one-cycle pulse on a drain event or counter overflow.

## Operation
- State machine with three states:
  - IDLE: all `snk_stall_o` are 1; all `src_*` control outputs are 0.
  - GRANT: the granted source is muxed straight through to the shared sink.
  - DRAIN: the link is held open until outstanding responses return.
- IDLE → GRANT when any `snk_cyc_i` is high.
  - Winner: the first requesting index searching upward, wrapping, from `last+1`.
  - `last` is the previous winner; it resets to N-1, so source 0 has first priority.
- In GRANT:
  - `src_* = snk_*[g]` combinationally.
  - `snk_stall_o[g] = src_stall_i`; `snk_ack_o[g]`, `snk_err_o[g]`, `snk_rty_o[g]` come from the sink.
  - Every non-granted source sees stall=1, ack=err=rty=0.
- Outstanding counter `outst`:
  - +1 on `src_stb_o & ~src_stall_i`; −1 on `ack|err|rty`; both together leave it unchanged.
  - At `g_MAX_OUTSTANDING` a further accepted strobe does not increment and pulses `proto_err_o`. `src_stall_i` is not overridden.
- GRANT exit when `snk_cyc_i[g]` falls:
  - `outst==0`, or `outst==1` with a response in that same cycle: go to IDLE.
  - Otherwise go to DRAIN, pulse `proto_err_o`, and update `last=g` on the transition either way.
- In DRAIN:
  - `src_cyc_o=1` and `src_stb_o=0`.
  - Responses are counted but are not forwarded to any source.
  - Exit to IDLE when the counter reaches 0.
- After leaving GRANT or DRAIN, the block always spends at least one cycle in IDLE before the next grant.
- If the granted source holds `cyc` high indefinitely, the grant holds indefinitely; there is no timeout.

## Timing
- Reset values: `grant_o=0`, `busy_o=0`, `proto_err_o=0`, `src_cyc_o=src_stb_o=src_we_o=0`, all `snk_stall_o=1`, all `snk_ack_o/err_o/rty_o=0`, `outst=0`, `last=N-1`, state IDLE.
- Reset asserted mid-packet forces these values immediately (asynchronously) and drops `src_cyc_o`.
- Grant latency: `cyc` seen in IDLE at edge t puts the block in GRANT from t+1; `src_cyc_o` is high in the cycle after t.
- Data, stall and ack paths through GRANT are combinational, with zero added latency.
- Release: `cyc` low at edge t puts the block in IDLE from t+1 (`src_cyc_o` low); the earliest next grant is at edge t+2.
- Simultaneous requests: only one wins; the others wait with stall=1 and must hold their `cyc`/`stb`.
- Registered outputs: `grant_o`, `busy_o`, `proto_err_o`.

## Test plan
- Reset, then source 1 alone sends a 4-beat packet, all acked with `src_stall_i=0` → `grant_o=2'b10` one cycle after `cyc`; 4 acks reach source 1; `snk_stall_o[0]=1` throughout; back to IDLE with `proto_err_o=0`.
- Both sources raise `cyc` in the same cycle with 3 packets each → grants alternate 0,1,0,1,0,1; the sink sees 6 unbroken packets with ≥1 idle cycle between them.
- Sink stalls randomly at 50% during a 16-beat packet → all 16 beats are delivered in order, data matches, and `outst` never exceeds its limit.
- Source 0 drops `cyc` with 2 strobes unacked → DRAIN is entered, `proto_err_o` pulses once, `src_cyc_o` stays high until 2 acks arrive, then IDLE; source 1 is granted afterwards.
- Reset asserted in the middle of a 16-beat packet → all outputs take their reset values in the same cycle; after release, source 0 wins first.
- Sink withholds acks for 16 accepted strobes with `g_MAX_OUTSTANDING=15` → `proto_err_o` pulses on the 16th and the counter saturates at 15.
